// File: rtl/dcim_pkg.sv
// Shared types and defaults for the DCIM sequencer: FSM state encoding, bus widths
// and the row-index to one-hot word-line helper.
package dcim_pkg;

    localparam int DEF_ROWS = 8;
    localparam int DEF_DW   = 24;
    localparam int DEF_XW   = 192;
    localparam int DEF_OW   = 51;
    localparam int DEF_TMO  = 1024;
    localparam int MAX_ROWS = 64;

    typedef enum logic [2:0] {
        IDLE,
        W_DRV,
        W_HOLD,
        W_GAP,
        C_SET,
        C_GO1,
        C_GO2,
        C_WAIT
    } state_e;

    // Out-of-range rows yield an all-zero word-line vector.
    function automatic logic [MAX_ROWS-1:0] onehot_row(input int row, input int rows);
        onehot_row = '0;
        if (row >= 0 && row < rows && row < MAX_ROWS) begin
            onehot_row = MAX_ROWS'(1) << row;
        end
    endfunction

endpackage

// File: rtl/dcim_if.sv
// Request, result and macro-drive bundle of the DCIM sequencer; slave is the sequencer view,
// master the requester/macro view. Handshakes are valid/ready, result held until r_ready.
interface dcim_if
    import dcim_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int DW   = DEF_DW,
    parameter int XW   = DEF_XW,
    parameter int OW   = DEF_OW
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic            cfg_cima;
    logic            cfg_inwidth;
    logic            cfg_wwidth;

    logic            w_valid;
    logic            w_ready;
    logic [RW-1:0]   w_row;
    logic [DW-1:0]   w_data;

    logic            c_valid;
    logic            c_ready;
    logic [XW-1:0]   c_x;

    logic            r_valid;
    logic            r_ready;
    logic [OW-1:0]   r_data;
    logic            r_tmo;

    logic [ROWS-1:0] wmask;
    logic            wclr;
    logic            busy;

    logic [ROWS-1:0] m_WA;
    logic [DW-1:0]   m_D;
    logic [XW-1:0]   m_xin0;
    logic            m_start;
    logic            m_cima;
    logic            m_inwidth;
    logic            m_wwidth;
    logic [OW-1:0]   m_nout;
    logic            m_st;

    modport slave (
        input  cfg_cima, cfg_inwidth, cfg_wwidth,
        input  w_valid, w_row, w_data,
        output w_ready,
        input  c_valid, c_x,
        output c_ready,
        output r_valid, r_data, r_tmo,
        input  r_ready,
        output wmask, busy,
        input  wclr,
        output m_WA, m_D, m_xin0, m_start, m_cima, m_inwidth, m_wwidth,
        input  m_nout, m_st
    );

    modport master (
        output cfg_cima, cfg_inwidth, cfg_wwidth,
        output w_valid, w_row, w_data,
        input  w_ready,
        output c_valid, c_x,
        input  c_ready,
        input  r_valid, r_data, r_tmo,
        output r_ready,
        input  wmask, busy,
        output wclr,
        input  m_WA, m_D, m_xin0, m_start, m_cima, m_inwidth, m_wwidth,
        output m_nout, m_st
    );

endinterface

// File: rtl/dcim_st_watch.sv
// Completion watcher: rising-edge detect on st and a timeout counter while armed; pulses
// are combinational in the deciding cycle. No backpressure, arm is a one-cycle strobe.
module dcim_st_watch
    import dcim_pkg::*;
#(
    parameter int TMO = DEF_TMO
) (
    input  logic clk,
    input  logic rst,
    input  logic st_i,
    input  logic arm_i,
    output logic done_pulse_o,
    output logic tmo_pulse_o
);
    localparam int CW = $clog2(TMO);

    logic          st_q;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          st_rise;

    assign st_rise      = st_i & ~st_q;
    assign done_pulse_o = armed_q & st_rise;
    // An edge in the final counted cycle still counts as completion.
    assign tmo_pulse_o  = armed_q & ~st_rise & (cnt_q == CW'(TMO - 1));

    always_comb begin
        armed_d = armed_q;
        cnt_d   = cnt_q;
        if (arm_i) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end else if (done_pulse_o || tmo_pulse_o) begin
            armed_d = 1'b0;
            cnt_d   = '0;
        end else if (armed_q) begin
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= 1'b0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_i;
            armed_q <= armed_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/dcim_seq_ctrl.sv
// DCIM macro sequencer: write = 4 cycles accept-to-ready, compute = start 2 cycles after accept,
// result 1 cycle after the st edge or TMO cycles after wait entry. Compute stalls while a result is unread.
module dcim_seq_ctrl
    import dcim_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int DW   = DEF_DW,
    parameter int XW   = DEF_XW,
    parameter int OW   = DEF_OW,
    parameter int TMO  = DEF_TMO
) (
    input  logic  clk,
    input  logic  rst,
    dcim_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [ROWS-1:0] wa_q, wa_d;
    logic [ROWS-1:0] wmask_q, wmask_d;
    logic [DW-1:0]   data_q, data_d;
    logic [XW-1:0]   xin_q, xin_d;
    logic            start_q, start_d;
    logic [2:0]      mode_q, mode_d;
    logic            r_valid_q, r_valid_d;
    logic [OW-1:0]   r_data_q, r_data_d;
    logic            r_tmo_q, r_tmo_d;

    logic            w_acc, c_acc;
    logic            arm, done_pulse, tmo_pulse;

    assign arm = (state_q == C_GO2);

    dcim_st_watch #(.TMO(TMO)) u_st_watch (
        .clk          (clk),
        .rst          (rst),
        .st_i         (bus.m_st),
        .arm_i        (arm),
        .done_pulse_o (done_pulse),
        .tmo_pulse_o  (tmo_pulse)
    );

    always_comb begin
        state_d = state_q;
        w_acc   = 1'b0;
        c_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                // Writes take priority; they may also proceed while a result is unread.
                if (bus.w_valid) begin
                    w_acc   = 1'b1;
                    state_d = W_DRV;
                end else if (bus.c_valid && !r_valid_q) begin
                    c_acc   = 1'b1;
                    state_d = C_SET;
                end
            end
            W_DRV:   state_d = W_HOLD;
            W_HOLD:  state_d = W_GAP;
            W_GAP:   state_d = IDLE;
            C_SET:   state_d = C_GO1;
            C_GO1:   state_d = C_GO2;
            C_GO2:   state_d = C_WAIT;
            C_WAIT: begin
                if (done_pulse || tmo_pulse) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        row_d     = w_acc ? bus.w_row  : row_q;
        data_d    = w_acc ? bus.w_data : data_q;
        xin_d     = c_acc ? bus.c_x    : xin_q;
        mode_d    = (w_acc || c_acc) ? {bus.cfg_cima, bus.cfg_inwidth, bus.cfg_wwidth} : mode_q;
        wa_d      = '0;
        if (state_d == W_DRV || state_d == W_HOLD) begin
            wa_d = ROWS'(onehot_row(int'(row_d), ROWS));
        end
        start_d   = (state_d == C_GO1) || (state_d == C_GO2);

        wmask_d   = wmask_q;
        if (state_q == IDLE && bus.wclr) begin
            wmask_d = '0;
        end
        if (state_q == W_HOLD) begin
            wmask_d = wmask_q | ROWS'(onehot_row(int'(row_q), ROWS));
        end

        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_tmo_d   = r_tmo_q;
        if (done_pulse) begin
            r_valid_d = 1'b1;
            r_data_d  = bus.m_nout;
            r_tmo_d   = 1'b0;
        end else if (tmo_pulse) begin
            r_valid_d = 1'b1;
            r_data_d  = '0;
            r_tmo_d   = 1'b1;
        end else if (r_valid_q && bus.r_ready) begin
            r_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            wa_q      <= '0;
            wmask_q   <= '0;
            data_q    <= '0;
            xin_q     <= '0;
            start_q   <= 1'b0;
            mode_q    <= '0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            r_tmo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            wa_q      <= wa_d;
            wmask_q   <= wmask_d;
            data_q    <= data_d;
            xin_q     <= xin_d;
            start_q   <= start_d;
            mode_q    <= mode_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_tmo_q   <= r_tmo_d;
        end
    end

    assign bus.w_ready   = (state_q == IDLE) && !rst;
    assign bus.c_ready   = (state_q == IDLE) && !r_valid_q && !rst;
    assign bus.busy      = (state_q != IDLE);
    assign bus.wmask     = wmask_q;
    assign bus.r_valid   = r_valid_q;
    assign bus.r_data    = r_data_q;
    assign bus.r_tmo     = r_tmo_q;
    assign bus.m_WA      = wa_q;
    assign bus.m_D       = data_q;
    assign bus.m_xin0    = xin_q;
    assign bus.m_start   = start_q;
    assign bus.m_cima    = mode_q[2];
    assign bus.m_inwidth = mode_q[1];
    assign bus.m_wwidth  = mode_q[0];

endmodule

// File: tb/tb_dcim_seq_ctrl.sv
// Bench for dcim_seq_ctrl: directed scenarios plus randomized write/compute traffic
// against a transaction-level timing model; the bench also plays the macro.
module tb_dcim_seq_ctrl;
    import dcim_pkg::*;

    localparam int ROWS = 8;
    localparam int DW   = 24;
    localparam int XW   = 192;
    localparam int OW   = 51;
    localparam int TMO  = 16;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    logic [ROWS-1:0] exp_mask;
    logic [2:0]      exp_mode;
    logic [XW-1:0]   exp_x;

    dcim_if #(.ROWS(ROWS), .DW(DW), .XW(XW), .OW(OW)) bus ();

    dcim_seq_ctrl #(.ROWS(ROWS), .DW(DW), .XW(XW), .OW(OW), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] v;
        for (int i = 0; i < XW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [OW-1:0] rand_nout();
        return OW'({$urandom, $urandom});
    endfunction

    task automatic chk_mode(input string tag);
        chk(tag, {bus.m_cima, bus.m_inwidth, bus.m_wwidth}, exp_mode);
    endtask

    task automatic set_cfg();
        exp_mode = 3'($urandom);
        {bus.cfg_cima, bus.cfg_inwidth, bus.cfg_wwidth} = exp_mode;
    endtask

    task automatic scramble_cfg();
        {bus.cfg_cima, bus.cfg_inwidth, bus.cfg_wwidth} = 3'($urandom);
    endtask

    task automatic do_write(input int row, input logic [DW-1:0] data, input bit clr);
        int n;
        logic [ROWS-1:0] oh;
        n = 0;
        while (!bus.w_ready && n < 16) begin
            tick();
            n++;
        end
        chk("w_ready_wait", bus.w_ready, 1);
        set_cfg();
        bus.w_valid = 1'b1;
        bus.w_row   = row[2:0];
        bus.w_data  = data;
        bus.wclr    = clr;
        tick();
        bus.w_valid = 1'b0;
        bus.wclr    = 1'b0;
        scramble_cfg();
        oh = 8'd1 << row;
        if (clr) exp_mask = '0;
        exp_mask = exp_mask | oh;
        chk("wa_t1", bus.m_WA, oh);
        chk("d_t1", bus.m_D, data);
        chk_mode("mode_w");
        chk("w_ready_t1", bus.w_ready, 0);
        tick();
        chk("wa_t2", bus.m_WA, oh);
        tick();
        chk("wa_t3", bus.m_WA, 0);
        chk("wmask_t3", bus.wmask, exp_mask);
        chk("d_hold", bus.m_D, data);
        tick();
        chk("w_ready_t4", bus.w_ready, 1);
        chk_mode("mode_hold_w");
    endtask

    // d = cycles after C_WAIT entry at which m_st rises; hold = m_st high throughout.
    task automatic do_compute(input logic [XW-1:0] x, input int d, input bit hold,
                              input logic [OW-1:0] nout, output int waited);
        int            exp_k;
        logic [OW-1:0] exp_data;
        bit            exp_tmo;
        waited      = 0;
        bus.c_valid = 1'b1;
        bus.c_x     = x;
        while (!bus.c_ready && waited < 16) begin
            tick();
            waited++;
        end
        chk("c_ready_wait", bus.c_ready, 1);
        set_cfg();
        if (hold) bus.m_st = 1'b1;
        tick();
        bus.c_valid = 1'b0;
        scramble_cfg();
        exp_x = x;
        chk("xin_t1", bus.m_xin0, x);
        chk("start_t1", bus.m_start, 0);
        chk_mode("mode_c");
        chk("busy_t1", bus.busy, 1);
        chk("c_ready_t1", bus.c_ready, 0);
        tick();
        chk("start_t2", bus.m_start, 1);
        tick();
        chk("start_t3", bus.m_start, 1);
        tick();
        chk("start_t4", bus.m_start, 0);
        chk_mode("mode_hold_c");
        if (hold || d >= TMO) begin
            exp_k    = TMO;
            exp_tmo  = 1'b1;
            exp_data = '0;
        end else begin
            exp_k    = d + 1;
            exp_tmo  = 1'b0;
            exp_data = nout;
        end
        for (int k = 0; k <= exp_k; k++) begin
            chk("r_valid_timing", bus.r_valid, (k == exp_k));
            if (k == exp_k) break;
            if (hold) begin
                bus.m_nout = rand_nout();
            end else begin
                bus.m_st   = (k >= d);
                bus.m_nout = (k >= d) ? nout : rand_nout();
            end
            tick();
        end
        chk("r_data", bus.r_data, exp_data);
        chk("r_tmo", bus.r_tmo, exp_tmo);
        chk("busy_done", bus.busy, 0);
        chk("c_ready_pend", bus.c_ready, 0);
        bus.m_st = 1'b0;
    endtask

    task automatic consume();
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        chk("r_consumed", bus.r_valid, 0);
        chk("c_ready_after", bus.c_ready, 1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            w;
        logic [OW-1:0] nv;
        logic [XW-1:0] xv;
        rst = 1'b1;
        {bus.cfg_cima, bus.cfg_inwidth, bus.cfg_wwidth} = 3'b0;
        bus.w_valid = 1'b0; bus.w_row = '0; bus.w_data = '0;
        bus.c_valid = 1'b0; bus.c_x = '0;
        bus.r_ready = 1'b0; bus.wclr = 1'b0;
        bus.m_nout  = '0;   bus.m_st = 1'b0;
        exp_mask = '0; exp_mode = '0; exp_x = '0;

        repeat (3) tick();
        chk("rst_w_ready", bus.w_ready, 0);
        chk("rst_c_ready", bus.c_ready, 0);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_r_data", bus.r_data, 0);
        chk("rst_wmask", bus.wmask, 0);
        chk("rst_wa", bus.m_WA, 0);
        chk("rst_start", bus.m_start, 0);
        chk("rst_xin", bus.m_xin0, 0);
        chk("rst_busy", bus.busy, 0);
        chk_mode("rst_mode");
        rst = 1'b0;
        #1;
        chk("rel_w_ready", bus.w_ready, 1);
        chk("rel_c_ready", bus.c_ready, 1);

        for (int i = 0; i < ROWS; i++) do_write(i, DW'(9 + i), 1'b0);
        chk("wmask_all", bus.wmask, 8'hFF);

        xv = {XW/4{4'ha}};
        do_compute(xv, 5, 1'b0, 51'h1234, w);
        consume();

        // Simultaneous write and compute: write first, compute accepted when IDLE returns.
        xv = rand_x();
        set_cfg();
        bus.w_valid = 1'b1; bus.w_row = 3'd3; bus.w_data = 24'h00abcd;
        bus.c_valid = 1'b1; bus.c_x = xv;
        tick();
        bus.w_valid = 1'b0;
        chk("arb_wa", bus.m_WA, 8'h08);
        chk("arb_xin_held", bus.m_xin0, exp_x);
        do_compute(xv, 2, 1'b0, rand_nout(), w);
        chk("arb_wait", w, 3);
        consume();

        do_compute(rand_x(), 0, 1'b1, rand_nout(), w);
        consume();
        do_compute(rand_x(), 1000, 1'b0, rand_nout(), w);
        consume();
        do_compute(rand_x(), TMO - 1, 1'b0, rand_nout(), w);
        consume();
        do_compute(rand_x(), 0, 1'b0, rand_nout(), w);
        consume();

        // Unread result: compute blocked, writes still flow.
        nv = rand_nout();
        do_compute(rand_x(), 2, 1'b0, nv, w);
        tick();
        chk("pend_c_ready", bus.c_ready, 0);
        do_write(5, 24'h5a5a5a, 1'b1);
        chk("pend_r_valid", bus.r_valid, 1);
        chk("pend_r_data", bus.r_data, nv);
        chk("pend_c_ready2", bus.c_ready, 0);
        consume();

        for (int it = 0; it < 40; it++) begin
            case ($urandom % 4)
                0, 1: do_write(int'($urandom % ROWS), DW'($urandom), ($urandom % 4) == 0);
                2: begin
                    do_compute(rand_x(), int'($urandom_range(0, TMO + 3)), ($urandom % 5) == 0,
                               rand_nout(), w);
                    repeat ($urandom % 3) begin
                        tick();
                        chk("rnd_c_ready_pend", bus.c_ready, 0);
                    end
                    consume();
                end
                default: begin
                    bus.wclr = 1'b1;
                    tick();
                    bus.wclr = 1'b0;
                    exp_mask = '0;
                    chk("wclr_idle", bus.wmask, 0);
                end
            endcase
        end

        if (exp_mask == '0) do_write(2, 24'h000777, 1'b0);
        chk("pre_rst_wmask", bus.wmask, exp_mask);

        // Reset while start is asserted.
        bus.c_valid = 1'b1;
        bus.c_x     = rand_x();
        set_cfg();
        tick();
        bus.c_valid = 1'b0;
        tick();
        chk("go1_start", bus.m_start, 1);
        rst = 1'b1;
        tick();
        exp_mask = '0; exp_mode = '0;
        chk("mid_rst_start", bus.m_start, 0);
        chk("mid_rst_wmask", bus.wmask, 0);
        chk("mid_rst_r_valid", bus.r_valid, 0);
        chk("mid_rst_xin", bus.m_xin0, 0);
        chk("mid_rst_d", bus.m_D, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_w_ready", bus.w_ready, 0);
        chk_mode("mid_rst_mode");
        rst = 1'b0;
        #1;
        chk("mid_rel_c_ready", bus.c_ready, 1);
        repeat (TMO + 4) tick();
        chk("mid_no_result", bus.r_valid, 0);
        chk("mid_idle_start", bus.m_start, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
